uart_hex_scan_display: RTL
==========================

// Module: uart_hex_scan_display
// PURPOSE
//  Displays the last NUM_BYTES bytes received over UART as hex on a multiplexed SSD bank.
//  Each byte drives 2 digits, so NUM_DIGITS = 2*NUM_BYTES. Sits after uart_communication
//  (rx_data/rx_valid) and feeds Segment_Selector-style decoding to the board pins.
//  Adds a latched byte buffer, a prescaled scan, per-digit dash-until-loaded, shift/ring
//  modes, clear and blank.
// PARAMETERS
//  NUM_BYTES   2        bytes shown; 1..8; digits = 2*NUM_BYTES
//  TICK_DIV    416_667  clk cycles per digit slot; >=2
//  SHIFT_MODE  1        1: new byte enters byte0, older bytes shift up; 0: ring write pointer
// PORTS
//  clk         in   1            system clock (50 MHz); single clock domain
//  rst         in   1            synchronous, active-high reset
//  rx_data     in   8            received UART byte
//  rx_valid    in   1            1-cycle strobe; rx_data is valid this cycle
//  clear       in   1            1-cycle strobe; empty the buffer (all digits back to dash)
//  blank       in   1            level; 1 forces dig_sel to all-zero, scan keeps running
//  segments    out  7            registered segment pattern for the selected digit
//  dig_sel     out  NUM_DIGITS   registered one-hot digit enable; bit0 = rightmost digit
//  dash        out  1            registered; 1 = selected digit shows dash (not yet loaded)
//  byte_count  out  4            bytes loaded since reset/clear; saturates at NUM_BYTES
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): buffer=0, valid flags=0, wr_ptr=0, byte_count=0,
//   prescaler=0, scan idx=0, dig_sel=1 (one-hot bit0), dash=1, segments=DASH_SEG.
//   rst overrides every other input.
//  Prescaler: cnt counts 0..TICK_DIV-1, then wraps to 0. tick=1 when cnt==TICK_DIV-1.
//   On tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
//  Digit map: digit 2k = byte k [3:0], digit 2k+1 = byte k [7:4]. Digit valid = byte k valid flag.
//  Load (rx_valid=1, clear=0):
//   SHIFT_MODE=1: byte[i] <= byte[i-1] and flag[i] <= flag[i-1] for i>0; byte0 <= rx_data;
//    flag0 <= 1.
//   SHIFT_MODE=0: byte[wr_ptr] <= rx_data; flag[wr_ptr] <= 1; wr_ptr wraps NUM_BYTES-1 -> 0
//    (overwrites the oldest byte).
//   byte_count <= min(byte_count+1, NUM_BYTES).
//  clear=1: all flags=0, wr_ptr=0, byte_count=0; buffer data is don't-care. clear beats rx_valid
//   in the same cycle (byte dropped). Scan timing is unaffected.
//  Output register, updated every cycle from idx and the buffer (pre-update values):
//   dig_sel <= blank ? 0 : (1<<idx); dash <= ~flag; segments <= flag ? HEX(nibble) : DASH_SEG.
//   Latency: rx_valid at edge k -> buffer at edge k -> outputs at edge k+1 when that digit is
//   being scanned. idx change at edge k -> outputs at edge k+1.
//  Rx strobes arriving back-to-back on every cycle are all accepted. No backpressure.
//  Reset asserted mid-scan or mid-load: the next cycle matches the reset state exactly.
// STRUCTURE
//  Shared package ssd_pkg: NIBBLE_W=4, BYTE_W=8, DASH_SEG constant, function hex_to_seg
//   (same polarity as Segment_Selector).
//  One sub-module: ssd_refresh_tick (TICK_DIV counter, sync reset, outputs the tick pulse).
//  Buffer, flags, pointer and scan index stay in this module. No other sub-modules.
// TESTING (NUM_BYTES=2, TICK_DIV=4 unless stated)
//  1. Reset only -> dig_sel steps 0001,0010,0100,1000,0001, changing every 4 clk; dash=1 and
//     segments=DASH_SEG at every step.
//  2. SHIFT_MODE=1; rx 0xA5 then 0x3C -> digits 0..3 show C,3,5,A; dash=0 throughout;
//     byte_count=2.
//  3. SHIFT_MODE=0; rx 0x11,0x22,0x33 -> byte0=0x33, byte1=0x22 (wrap); byte_count stays 2.
//  4. Single rx 0x7E -> digits 0,1 show E,7; digits 2,3 show dash; byte_count=1.
//  5. clear together with rx_valid(0x55) after 2 loads -> all digits dash, byte_count=0,
//     scan phase unchanged.
//  6. blank=1 -> dig_sel=0 while idx keeps advancing; release blank mid-scan -> the next one-hot
//     value is consistent with an uninterrupted count. rst mid-scan -> dig_sel=0001, dash=1 on
//     the next edge.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared seven-segment constants and nibble-to-segment decode (active-low, bit order g..a).
// Pure combinational helpers; no latency, no flow control.
// Used by any block that drives the multiplexed SSD bank.
package ssd_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;
    localparam int SEG_W    = 7;

    // Only segment g lit: a dash.
    localparam logic [SEG_W-1:0] DASH_SEG = 7'b0111111;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// Digit-slot prescaler: one-cycle tick every TICK_DIV clocks.
// Tick asserted combinationally while the counter sits at TICK_DIV-1.
// Free-running; no backpressure.
module ssd_refresh_tick #(
    parameter int TICK_DIV = 416_667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_hex_scan_display.sv
// Shows the last NUM_BYTES UART bytes as hex on a multiplexed SSD bank; unloaded digits show a dash.
// Outputs registered: one cycle after the buffer / scan index change.
// No backpressure: every rx_valid strobe is accepted, even back-to-back.
module uart_hex_scan_display
    import ssd_pkg::*;
#(
    parameter int NUM_BYTES  = 2,
    parameter int TICK_DIV   = 416_667,
    parameter int SHIFT_MODE = 1,
    localparam int NUM_DIGITS = 2 * NUM_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    input  logic                  clear,
    input  logic                  blank,
    output logic [SEG_W-1:0]      segments,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  dash,
    output logic [3:0]            byte_count
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [BYTE_W-1:0]    byte_q [NUM_BYTES];
    logic [NUM_BYTES-1:0] flag_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [IW-1:0]        idx_q;
    logic                 tick;

    logic [PW-1:0]        sel_byte;
    logic                 sel_flag;
    logic [NIBBLE_W-1:0]  sel_nib;

    ssd_refresh_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                byte_q[i] <= '0;
            end
            flag_q     <= '0;
            wr_ptr_q   <= '0;
            byte_count <= '0;
        end else if (clear) begin
            // clear wins over a coincident rx strobe; data bytes are left stale.
            flag_q     <= '0;
            wr_ptr_q   <= '0;
            byte_count <= '0;
        end else if (rx_valid) begin
            if (SHIFT_MODE != 0) begin
                for (int i = NUM_BYTES - 1; i > 0; i--) begin
                    byte_q[i] <= byte_q[i-1];
                    flag_q[i] <= flag_q[i-1];
                end
                byte_q[0] <= rx_data;
                flag_q[0] <= 1'b1;
            end else begin
                byte_q[wr_ptr_q] <= rx_data;
                flag_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q <= (wr_ptr_q == PW'(NUM_BYTES - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (byte_count != 4'(NUM_BYTES)) begin
                byte_count <= byte_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (tick) begin
            idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit 2k is the low nibble of byte k, digit 2k+1 the high nibble.
    assign sel_byte = PW'(idx_q >> 1);
    assign sel_flag = flag_q[sel_byte];
    assign sel_nib  = idx_q[0] ? byte_q[sel_byte][7:4] : byte_q[sel_byte][3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_sel  <= NUM_DIGITS'(1);
            dash     <= 1'b1;
            segments <= DASH_SEG;
        end else begin
            dig_sel  <= blank ? '0 : (NUM_DIGITS'(1) << idx_q);
            dash     <= ~sel_flag;
            segments <= sel_flag ? hex_to_seg(sel_nib) : DASH_SEG;
        end
    end

endmodule
